// File: rtl/rggen_bit_field_counter_pkg.sv
// ============================================================================
// rggen_bit_field_counter_pkg : shared access/count-mode codes and enums
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef RGGEN_COUNTER_WRAP
`define RGGEN_COUNTER_WRAP 0
`endif
`ifndef RGGEN_COUNTER_SATURATE
`define RGGEN_COUNTER_SATURATE 1
`endif
`ifndef RGGEN_READ_DEFAULT
`define RGGEN_READ_DEFAULT 0
`endif
`ifndef RGGEN_READ_CLEAR
`define RGGEN_READ_CLEAR 1
`endif
`ifndef RGGEN_WRITE_DEFAULT
`define RGGEN_WRITE_DEFAULT 0
`endif
`ifndef RGGEN_WRITE_NONE
`define RGGEN_WRITE_NONE 1
`endif
`ifndef RGGEN_HW_ACCESS
`define RGGEN_HW_ACCESS 0
`endif
`ifndef RGGEN_SW_ACCESS
`define RGGEN_SW_ACCESS 1
`endif

package rggen_bit_field_counter_pkg;
    localparam int RGGEN_COUNTER_WRAP_P     = `RGGEN_COUNTER_WRAP;
    localparam int RGGEN_COUNTER_SATURATE_P = `RGGEN_COUNTER_SATURATE;
    localparam int RGGEN_READ_DEFAULT_P     = `RGGEN_READ_DEFAULT;
    localparam int RGGEN_READ_CLEAR_P       = `RGGEN_READ_CLEAR;
    localparam int RGGEN_WRITE_DEFAULT_P    = `RGGEN_WRITE_DEFAULT;
    localparam int RGGEN_WRITE_NONE_P       = `RGGEN_WRITE_NONE;
    localparam int RGGEN_HW_ACCESS_P        = `RGGEN_HW_ACCESS;
    localparam int RGGEN_SW_ACCESS_P        = `RGGEN_SW_ACCESS;

    // Source of the value the step delta is added to, highest priority first.
    typedef enum logic [1:0] {
        BASE_CLEAR      = 2'd0,
        BASE_WRITE      = 2'd1,
        BASE_READ_CLEAR = 2'd2,
        BASE_COUNT      = 2'd3
    } base_sel_e;
endpackage

`default_nettype wire

// File: rtl/rggen_bit_field_counter_next.sv
// ============================================================================
// rggen_counter_next : base + up - down with wrap/saturate and flow flags
// Revision: 1.0
// ============================================================================
`default_nettype none

module rggen_counter_next
    import rggen_bit_field_counter_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int STEP_WIDTH = 4,
    parameter int COUNT_MODE = `RGGEN_COUNTER_WRAP
) (
    input  logic [WIDTH-1:0]      i_base,
    input  logic                  i_apply_delta,
    input  logic                  i_up,
    input  logic [STEP_WIDTH-1:0] i_up_step,
    input  logic                  i_down,
    input  logic [STEP_WIDTH-1:0] i_down_step,
    output logic [WIDTH-1:0]      o_next,
    output logic                  o_overflow,
    output logic                  o_underflow
);
    localparam int SUM_W = WIDTH + 2;

    logic signed [SUM_W-1:0] sum;

    always_comb begin
        sum = $signed({2'b00, i_base});
        if (i_apply_delta) begin
            if (i_up) begin
                sum = sum + $signed({{(SUM_W-STEP_WIDTH){1'b0}}, i_up_step});
            end
            if (i_down) begin
                sum = sum - $signed({{(SUM_W-STEP_WIDTH){1'b0}}, i_down_step});
            end
        end
        // Two guard bits: MSB set means negative, bit WIDTH set alone means above all-ones.
        o_underflow = sum[SUM_W-1];
        o_overflow  = !sum[SUM_W-1] && sum[WIDTH];
        o_next      = sum[WIDTH-1:0];
        if (COUNT_MODE == RGGEN_COUNTER_SATURATE_P) begin
            if (o_overflow) begin
                o_next = '1;
            end else if (o_underflow) begin
                o_next = '0;
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/rggen_bit_field_counter.sv
// ============================================================================
// rggen_bit_field_counter : SW-accessible up/down event counter bit field
// Revision: 1.0
// ============================================================================
`default_nettype none

module rggen_bit_field_counter
    import rggen_bit_field_counter_pkg::*;
#(
    parameter int               WIDTH             = 16,
    parameter int               STEP_WIDTH        = 4,
    parameter logic [WIDTH-1:0] INITIAL_VALUE     = {WIDTH{1'b0}},
    parameter int               COUNT_MODE        = `RGGEN_COUNTER_WRAP,
    parameter int               SW_READ_ACTION    = `RGGEN_READ_DEFAULT,
    parameter int               SW_WRITE_ACTION   = `RGGEN_WRITE_DEFAULT,
    parameter int               PRECEDENCE_ACCESS = `RGGEN_HW_ACCESS
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sw_valid,
    input  logic [WIDTH-1:0]      i_sw_read_mask,
    input  logic                  i_sw_write_enable,
    input  logic [WIDTH-1:0]      i_sw_write_mask,
    input  logic [WIDTH-1:0]      i_sw_write_data,
    output logic [WIDTH-1:0]      o_sw_read_data,
    output logic [WIDTH-1:0]      o_sw_value,
    input  logic                  i_up,
    input  logic [STEP_WIDTH-1:0] i_up_step,
    input  logic                  i_down,
    input  logic [STEP_WIDTH-1:0] i_down_step,
    input  logic                  i_clear,
    input  logic [WIDTH-1:0]      i_threshold,
    output logic [WIDTH-1:0]      o_count,
    output logic                  o_overflow,
    output logic                  o_underflow,
    output logic                  o_threshold_hit
);
    logic [WIDTH-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             sw_write;
    logic             sw_read_clear;
    base_sel_e        base_sel;
    logic [WIDTH-1:0] base;
    logic             apply_delta;

    always_comb begin
        sw_write      = i_sw_valid && i_sw_write_enable && (|i_sw_write_mask) &&
                        (SW_WRITE_ACTION != RGGEN_WRITE_NONE_P);
        sw_read_clear = (SW_READ_ACTION == RGGEN_READ_CLEAR_P) && i_sw_valid &&
                        (|i_sw_read_mask) && !i_sw_write_enable;
        if (i_clear) begin
            base_sel = BASE_CLEAR;
        end else if (sw_write) begin
            base_sel = BASE_WRITE;
        end else if (sw_read_clear) begin
            base_sel = BASE_READ_CLEAR;
        end else begin
            base_sel = BASE_COUNT;
        end
    end

    // A read-clear keeps same-cycle events so nothing counted is lost.
    always_comb begin
        base        = count_q;
        apply_delta = 1'b1;
        unique case (base_sel)
            BASE_CLEAR: begin
                base        = INITIAL_VALUE;
                apply_delta = 1'b0;
            end
            BASE_WRITE: begin
                base        = (count_q & ~i_sw_write_mask) | (i_sw_write_data & i_sw_write_mask);
                apply_delta = (PRECEDENCE_ACCESS == RGGEN_HW_ACCESS_P);
            end
            BASE_READ_CLEAR: base = '0;
            default:         base = count_q;
        endcase
    end

    rggen_counter_next #(
        .WIDTH      (WIDTH),
        .STEP_WIDTH (STEP_WIDTH),
        .COUNT_MODE (COUNT_MODE)
    ) u_next (
        .i_base        (base),
        .i_apply_delta (apply_delta),
        .i_up          (i_up),
        .i_up_step     (i_up_step),
        .i_down        (i_down),
        .i_down_step   (i_down_step),
        .o_next        (count_d),
        .o_overflow    (overflow_d),
        .o_underflow   (underflow_d)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q     <= INITIAL_VALUE;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_sw_read_data  = count_q;
    assign o_sw_value      = count_q;
    assign o_count         = count_q;
    assign o_overflow      = overflow_q;
    assign o_underflow     = underflow_q;
    assign o_threshold_hit = (count_q >= i_threshold);
endmodule

`default_nettype wire

// File: tb/tb_rggen_bit_field_counter.sv
// ============================================================================
// tb_rggen_bit_field_counter : three configurations against an integer model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rggen_bit_field_counter;
    import rggen_bit_field_counter_pkg::*;

    localparam int W     = 8;
    localparam int SW    = 4;
    localparam int N     = 3;
    localparam int LIMIT = (1 << W) - 1;

    localparam int CFG_MODE [N] = '{RGGEN_COUNTER_WRAP_P, RGGEN_COUNTER_SATURATE_P, RGGEN_COUNTER_WRAP_P};
    localparam int CFG_RD   [N] = '{RGGEN_READ_DEFAULT_P, RGGEN_READ_CLEAR_P, RGGEN_READ_CLEAR_P};
    localparam int CFG_WR   [N] = '{RGGEN_WRITE_DEFAULT_P, RGGEN_WRITE_DEFAULT_P, RGGEN_WRITE_NONE_P};
    localparam int CFG_PREC [N] = '{RGGEN_HW_ACCESS_P, RGGEN_SW_ACCESS_P, RGGEN_HW_ACCESS_P};
    localparam int CFG_INIT [N] = '{0, 'h5A, 'h80};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sw_valid, we, up, dn, clr;
    logic [W-1:0]  rmask, wmask, wdata, thr;
    logic [SW-1:0] ustep, dstep;

    logic [W-1:0] rd_o  [N];
    logic [W-1:0] val_o [N];
    logic [W-1:0] cnt_o [N];
    logic         ov_o  [N];
    logic         un_o  [N];
    logic         hit_o [N];

    int checks   = 0;
    int failures = 0;
    int m_cnt [N];
    int m_ov  [N];
    int m_un  [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        rggen_bit_field_counter #(
            .WIDTH             (W),
            .STEP_WIDTH        (SW),
            .INITIAL_VALUE     (W'(CFG_INIT[g])),
            .COUNT_MODE        (CFG_MODE[g]),
            .SW_READ_ACTION    (CFG_RD[g]),
            .SW_WRITE_ACTION   (CFG_WR[g]),
            .PRECEDENCE_ACCESS (CFG_PREC[g])
        ) u_dut (
            .i_clk             (clk),
            .i_rst_n           (rst_n),
            .i_sw_valid        (sw_valid),
            .i_sw_read_mask    (rmask),
            .i_sw_write_enable (we),
            .i_sw_write_mask   (wmask),
            .i_sw_write_data   (wdata),
            .o_sw_read_data    (rd_o[g]),
            .o_sw_value        (val_o[g]),
            .i_up              (up),
            .i_up_step         (ustep),
            .i_down            (dn),
            .i_down_step       (dstep),
            .i_clear           (clr),
            .i_threshold       (thr),
            .o_count           (cnt_o[g]),
            .o_overflow        (ov_o[g]),
            .o_underflow       (un_o[g]),
            .o_threshold_hit   (hit_o[g])
        );
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input logic [W-1:0] rm, input bit w, input logic [W-1:0] wm,
                         input logic [W-1:0] wd, input bit u, input logic [SW-1:0] us,
                         input bit d, input logic [SW-1:0] ds, input bit c);
        sw_valid = v; rmask = rm; we = w; wmask = wm; wdata = wd;
        up = u; ustep = us; dn = d; dstep = ds; clr = c;
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_cnt[k] = CFG_INIT[k];
            m_ov[k]  = 0;
            m_un[k]  = 0;
        end
    endtask

    // Integer-arithmetic reference: choose a base, add the signed delta, then fold.
    task automatic model_step();
        for (int k = 0; k < N; k++) begin
            int base, delta, sum;
            bit wr, rc;
            delta = (up ? int'(ustep) : 0) - (dn ? int'(dstep) : 0);
            wr = sw_valid && we && (wmask != 0) && (CFG_WR[k] != RGGEN_WRITE_NONE_P);
            rc = (CFG_RD[k] == RGGEN_READ_CLEAR_P) && sw_valid && (rmask != 0) && !we;
            if (clr) begin
                base  = CFG_INIT[k];
                delta = 0;
            end else if (wr) begin
                base = (m_cnt[k] & ~int'(wmask)) | (int'(wdata) & int'(wmask));
                if (CFG_PREC[k] == RGGEN_SW_ACCESS_P) delta = 0;
            end else if (rc) begin
                base = 0;
            end else begin
                base = m_cnt[k];
            end
            sum      = base + delta;
            m_ov[k]  = 0;
            m_un[k]  = 0;
            if (sum > LIMIT) begin
                m_ov[k]  = 1;
                m_cnt[k] = (CFG_MODE[k] == RGGEN_COUNTER_WRAP_P) ? sum - (LIMIT + 1) : LIMIT;
            end else if (sum < 0) begin
                m_un[k]  = 1;
                m_cnt[k] = (CFG_MODE[k] == RGGEN_COUNTER_WRAP_P) ? sum + (LIMIT + 1) : 0;
            end else begin
                m_cnt[k] = sum;
            end
        end
    endtask

    task automatic check_comb();
        #1;
        for (int k = 0; k < N; k++) begin
            check_value($sformatf("rd_data%0d", k), 32'(rd_o[k]), 32'(m_cnt[k]));
            check_value($sformatf("thr_hit%0d", k), 32'(hit_o[k]), 32'(m_cnt[k] >= int'(thr)));
        end
    endtask

    task automatic check_reg();
        for (int k = 0; k < N; k++) begin
            check_value($sformatf("count%0d", k), 32'(cnt_o[k]), 32'(m_cnt[k]));
            check_value($sformatf("sw_value%0d", k), 32'(val_o[k]), 32'(m_cnt[k]));
            check_value($sformatf("ovf%0d", k), 32'(ov_o[k]), 32'(m_ov[k]));
            check_value($sformatf("unf%0d", k), 32'(un_o[k]), 32'(m_un[k]));
        end
    endtask

    task automatic tick();
        check_comb();
        model_step();
        @(posedge clk);
        #1;
        check_reg();
    endtask

    task automatic sw_wr(input logic [W-1:0] data);
        drive(1, 0, 1, 8'hFF, data, 0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        thr   = 8'd5;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reg();
        rst_n = 1'b1;

        // Wrap vs saturate on overflow, pulse lasts one cycle
        sw_wr(8'd250);
        drive(0, 0, 0, 0, 0, 1, 4'd9, 0, 0, 0);
        tick();
        check_value("plan_wrap_cnt", 32'(cnt_o[0]), 32'd3);
        check_value("plan_wrap_ovf", 32'(ov_o[0]), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_value("plan_ovf_drop", 32'(ov_o[0]), 32'd0);

        // Saturating underflow then recovery
        sw_wr(8'd2);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 4'd5, 0);
        tick();
        check_value("plan_sat_zero", 32'(cnt_o[1]), 32'd0);
        check_value("plan_sat_unf", 32'(un_o[1]), 32'd1);
        drive(0, 0, 0, 0, 0, 1, 4'd3, 0, 0, 0);
        tick();
        check_value("plan_sat_up", 32'(cnt_o[1]), 32'd3);

        // Read-clear keeps same-cycle increment
        sw_wr(8'd40);
        drive(1, 8'hFF, 0, 0, 0, 1, 4'd2, 0, 0, 0);
        #1;
        check_value("plan_rc_rdata", 32'(rd_o[1]), 32'd40);
        tick();
        check_value("plan_rc_cnt", 32'(cnt_o[1]), 32'd2);

        // Precedence: HW adds delta on top of write, SW drops it
        drive(1, 0, 1, 8'hFF, 8'h10, 1, 4'd1, 0, 0, 0);
        tick();
        check_value("plan_hw_prec", 32'(cnt_o[0]), 32'h11);
        check_value("plan_sw_prec", 32'(cnt_o[1]), 32'h10);

        // Clear dominates write and events
        drive(1, 0, 1, 8'hFF, 8'h33, 1, 4'd7, 0, 0, 1);
        tick();
        check_value("plan_clear", 32'(cnt_o[1]), 32'h5A);

        // Threshold boundary
        sw_wr(8'd5);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_value("plan_thr_eq", 32'(hit_o[0]), 32'd1);
        tick();
        sw_wr(8'd4);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_value("plan_thr_below", 32'(hit_o[0]), 32'd0);
        tick();

        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 3) == 0,
                  ($urandom % 2) ? W'($urandom) : '0,
                  ($urandom % 2) == 1,
                  ($urandom % 4) == 0 ? '0 : (($urandom % 2) ? 8'hFF : W'($urandom)),
                  W'($urandom),
                  ($urandom % 2) == 1, SW'($urandom),
                  ($urandom % 2) == 1, SW'($urandom),
                  ($urandom % 16) == 0);
            thr = W'($urandom);
            tick();
        end

        // Asynchronous reset mid-count with events held
        thr = 8'd5;
        drive(0, 0, 0, 0, 0, 1, 4'd3, 0, 0, 0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reg();
        @(posedge clk);
        #1;
        check_reg();
        rst_n = 1'b1;
        tick();
        check_value("plan_resume", 32'(cnt_o[0]), 32'd3);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
